axi_rd_sram: RTL

//  AXI4 read-channel responder (AR/R only) backed by an internal word-addressed SRAM array.

---
 rtl/axi_rd_sram_pkg.sv | 23 ++
 rtl/axi_rd_sram_burst_addr.sv | 31 +++
 rtl/axi_rd_sram.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/axi_rd_sram_pkg.sv
// Shared burst/response codes and read FSM state type for the AXI read SRAM responder.
package axi_rd_sram_pkg;

   localparam logic [1:0] BurstFixed = 2'b00;
   localparam logic [1:0] BurstIncr  = 2'b01;
   localparam logic [1:0] BurstWrap  = 2'b10;
   localparam logic [1:0] BurstRsvd  = 2'b11;

   localparam logic [1:0] RespOkay   = 2'b00;
   localparam logic [1:0] RespSlverr = 2'b10;

   typedef enum logic [1:0] {
      StIdle,
      StWait,
      StBeat
   } rd_state_e;

   // Legal WRAP lengths are 2, 4, 8 or 16 beats.
   function automatic logic wrap_len_ok(input logic [7:0] len);
      return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
   endfunction

endpackage

// File: rtl/axi_rd_sram_burst_addr.sv
// Combinational AXI4 next-beat address generator with WRAP legality check.
module axi_rd_sram_burst_addr
   import axi_rd_sram_pkg::*;
(
   input  logic [31:0] addr_i,
   input  logic [2:0]  size_i,
   input  logic [7:0]  len_i,
   input  logic [1:0]  burst_i,
   output logic [31:0] next_addr_o,
   output logic        wrap_err_o
);

   logic [31:0] step;
   logic [31:0] incr;
   logic [31:0] cont_mask;

   always_comb begin
      step      = 32'd1 << size_i;
      incr      = addr_i + step;
      // Container is only a power of two for legal WRAP lengths; otherwise the beat errors anyway.
      cont_mask = ((32'(len_i) + 32'd1) << size_i) - 32'd1;
      unique case (burst_i)
         BurstFixed: next_addr_o = addr_i;
         BurstWrap:  next_addr_o = (addr_i & ~cont_mask) | (incr & cont_mask);
         default:    next_addr_o = incr;
      endcase
      wrap_err_o = (burst_i == BurstWrap) &&
                   (!wrap_len_ok(len_i) || ((addr_i & (step - 32'd1)) != 32'd0));
   end

endmodule

// File: rtl/axi_rd_sram.sv
// AXI4 read-only responder backed by a word-addressed SRAM with a preload write port.
// Optional first-beat latency is enabled by defining RD_LATENCY_EN (adds the LAT parameter).
module axi_rd_sram
   import axi_rd_sram_pkg::*;
#(
   parameter int unsigned DEPTH     = 1024,
   parameter logic [31:0] BASE      = 32'h8000_0000,
   parameter string       INIT_FILE = ""
`ifdef RD_LATENCY_EN
   ,
   parameter int unsigned LAT       = 2
`endif
) (
   input  logic        clk_i,
   input  logic        rst_i,
   output logic        arready_o,
   input  logic        arvalid_i,
   input  logic [31:0] araddr_i,
   input  logic [3:0]  arid_i,
   input  logic [7:0]  arlen_i,
   input  logic [2:0]  arsize_i,
   input  logic [1:0]  arburst_i,
   input  logic        rready_i,
   output logic        rvalid_o,
   output logic [1:0]  rresp_o,
   output logic [31:0] rdata_o,
   output logic        rlast_o,
   output logic [3:0]  rid_o,
   input  logic        we_i,
   input  logic [31:0] waddr_i,
   input  logic [31:0] wdata_i
);

   localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [32:0] Span = 33'(DEPTH) << 2;

`ifdef RD_LATENCY_EN
   localparam bit UseWait = (LAT != 0);
`else
   localparam bit UseWait = 1'b0;
`endif

   logic [31:0] mem_q [DEPTH];

   rd_state_e   state_q;
   logic        arready_q, rvalid_q, rlast_q, werr_q;
   logic [1:0]  rresp_q, burst_q;
   logic [31:0] rdata_q, addr_q;
   logic [3:0]  rid_q;
   logic [7:0]  len_q, cnt_q;
   logic [2:0]  size_q;

   logic        hs, beat_hs, launch, lat_done;
   logic [31:0] ba_addr, ba_next;
   logic [2:0]  ba_size;
   logic [7:0]  ba_len;
   logic [1:0]  ba_burst;
   logic        ba_werr;
   logic [31:0] l_addr, l_off;
   logic [7:0]  l_cnt, l_len;
   logic [2:0]  l_size;
   logic [1:0]  l_burst;
   logic        l_werr, l_err;
   logic [AW-1:0] l_idx;
   logic [31:0] w_off;
   logic [AW-1:0] w_idx;
   logic        w_ok;

`ifdef RD_LATENCY_EN
   logic [31:0] lat_q;
   assign lat_done = (lat_q == LAT - 32'd1);
`else
   assign lat_done = 1'b0;
`endif

   axi_rd_sram_burst_addr u_burst_addr (
      .addr_i      (ba_addr),
      .size_i      (ba_size),
      .len_i       (ba_len),
      .burst_i     (ba_burst),
      .next_addr_o (ba_next),
      .wrap_err_o  (ba_werr)
   );

   always_comb begin
      hs      = arvalid_i & arready_q;
      beat_hs = rvalid_q & rready_i;
      // In IDLE the generator checks the incoming request; afterwards it steps the current beat.
      if (state_q == StIdle) begin
         ba_addr  = araddr_i;
         ba_size  = arsize_i;
         ba_len   = arlen_i;
         ba_burst = arburst_i;
      end else begin
         ba_addr  = addr_q;
         ba_size  = size_q;
         ba_len   = len_q;
         ba_burst = burst_q;
      end

      launch  = 1'b0;
      l_addr  = addr_q;
      l_cnt   = 8'd0;
      l_size  = size_q;
      l_burst = burst_q;
      l_len   = len_q;
      l_werr  = werr_q;
      unique case (state_q)
         StIdle: begin
            if (hs && !UseWait) begin
               launch  = 1'b1;
               l_addr  = araddr_i;
               l_size  = arsize_i;
               l_burst = arburst_i;
               l_len   = arlen_i;
               l_werr  = ba_werr;
            end
         end
         StWait: launch = lat_done;
         StBeat: begin
            if (beat_hs && !rlast_q) begin
               launch = 1'b1;
               l_addr = ba_next;
               l_cnt  = cnt_q + 8'd1;
            end
         end
         default: ;
      endcase

      l_off = l_addr - BASE;
      l_err = ({1'b0, l_off} >= Span) || (l_size > 3'd2) || (l_burst == BurstRsvd) || l_werr;
      l_idx = AW'(l_off >> 2);

      w_off = waddr_i - BASE;
      w_ok  = ({1'b0, w_off} < Span);
      w_idx = AW'(w_off >> 2);
   end

   always_ff @(posedge clk_i) begin
      if (we_i && w_ok) mem_q[w_idx] <= wdata_i;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= StIdle;
         arready_q <= 1'b1;
         rvalid_q  <= 1'b0;
         rlast_q   <= 1'b0;
         rresp_q   <= RespOkay;
         rid_q     <= 4'd0;
         rdata_q   <= 32'd0;
         cnt_q     <= 8'd0;
         addr_q    <= 32'd0;
         len_q     <= 8'd0;
         size_q    <= 3'd0;
         burst_q   <= BurstFixed;
         werr_q    <= 1'b0;
`ifdef RD_LATENCY_EN
         lat_q     <= 32'd0;
`endif
      end else begin
         // Data is captured at launch so later preload writes cannot disturb a held beat.
         if (launch) begin
            rvalid_q <= 1'b1;
            rdata_q  <= l_err ? 32'd0 : mem_q[l_idx];
            rresp_q  <= l_err ? RespSlverr : RespOkay;
            rlast_q  <= (l_cnt == l_len);
            cnt_q    <= l_cnt;
            addr_q   <= l_addr;
         end
         unique case (state_q)
            StIdle: begin
               if (hs) begin
                  arready_q <= 1'b0;
                  rid_q     <= arid_i;
                  len_q     <= arlen_i;
                  size_q    <= arsize_i;
                  burst_q   <= arburst_i;
                  werr_q    <= ba_werr;
                  addr_q    <= araddr_i;
                  state_q   <= UseWait ? StWait : StBeat;
`ifdef RD_LATENCY_EN
                  lat_q     <= 32'd0;
`endif
               end
            end
            StWait: begin
`ifdef RD_LATENCY_EN
               lat_q <= lat_q + 32'd1;
`endif
               if (lat_done) state_q <= StBeat;
            end
            StBeat: begin
               if (beat_hs && rlast_q) begin
                  state_q   <= StIdle;
                  arready_q <= 1'b1;
                  rvalid_q  <= 1'b0;
                  rlast_q   <= 1'b0;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign arready_o = arready_q;
   assign rvalid_o  = rvalid_q;
   assign rresp_o   = rresp_q;
   assign rdata_o   = rdata_q;
   assign rlast_o   = rlast_q;
   assign rid_o     = rid_q;

endmodule
